// File: rtl/eth_parser_pkg.sv
`default_nettype none
// ============================================================================
// Package  : eth_parser_pkg
// Brief    : Shared parser/filter types, broadcast constant and filter decision
// Revision : 1.0
// ============================================================================
package eth_parser_pkg;

    typedef logic [47:0] mac_addr_t;

    localparam mac_addr_t BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        mac_addr_t dst_mac;
        logic      is_ipv4;
        logic      is_ipv6;
        logic      is_arp;
        logic      is_unknown;
    } eth_metadata_t;

    typedef enum logic [1:0] {
        S_RECV      = 2'd0,
        S_OVF       = 2'd1,
        S_WAIT_META = 2'd2
    } filt_state_e;

    // proto_mask bit order is {unknown, arp, ipv6, ipv4}
    function automatic logic filter_accept(
        input eth_metadata_t meta,
        input mac_addr_t     local_mac,
        input logic          accept_bcast,
        input logic          accept_mcast,
        input logic [3:0]    proto_mask
    );
        logic is_bcast;
        logic mac_ok;
        logic proto_ok;
        is_bcast = (meta.dst_mac == BCAST_MAC);
        mac_ok   = (meta.dst_mac == local_mac)
                 || (accept_bcast && is_bcast)
                 || (accept_mcast && meta.dst_mac[40] && !is_bcast);
        proto_ok = (proto_mask[0] & meta.is_ipv4)
                 | (proto_mask[1] & meta.is_ipv6)
                 | (proto_mask[2] & meta.is_arp)
                 | (proto_mask[3] & meta.is_unknown);
        return mac_ok && proto_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module   : pkt_buffer_ram
// Brief    : Simple dual-port packet RAM, synchronous read that holds when idle
// Revision : 1.0
// ============================================================================
module pkt_buffer_ram
    import eth_parser_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/eth_frame_filter.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_filter
// Brief    : Store-and-forward MAC/protocol frame filter with overflow drop
// Revision : 1.0
// ============================================================================
module eth_frame_filter
    import eth_parser_pkg::*;
#(
    parameter int         DATA_WIDTH   = 8,
    parameter int         DEPTH        = 2048,
    parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
    parameter bit         ACCEPT_BCAST = 1'b1,
    parameter bit         ACCEPT_MCAST = 1'b0,
    parameter logic [3:0] PROTO_MASK   = 4'b0111
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  eth_metadata_t         s_meta,
    input  logic                  s_meta_valid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [31:0]           cnt_accept,
    output logic [31:0]           cnt_drop_filter,
    output logic [31:0]           cnt_drop_ovf
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            PW       = AW + 1;
    localparam int            EW       = DATA_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    filt_state_e     state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    eth_metadata_t   meta_q, meta_d;
    logic            meta_pend_q, meta_pend_d;
    logic            run_q, run_d;
    logic [31:0]     cnt_acc_q, cnt_acc_d;
    logic [31:0]     cnt_flt_q, cnt_flt_d;
    logic [31:0]     cnt_ovf_q, cnt_ovf_d;

    logic            r1_valid_q, r1_valid_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            m_tlast_q, m_tlast_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;

    logic            full;
    logic            beat;
    logic            ram_we;
    logic            decide;
    logic            accept;
    eth_metadata_t   dec_meta;
    logic            readable;
    logic            out_load;
    logic            rd_en;
    logic [EW-1:0]   ram_rd;

    assign full     = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    assign s_tready = run_q && (state_q != S_WAIT_META);
    assign beat     = s_tvalid && s_tready;
    // Metadata arriving with the deciding beat wins over the latched copy
    assign dec_meta = s_meta_valid ? s_meta : meta_q;
    assign accept   = filter_accept(dec_meta, LOCAL_MAC, ACCEPT_BCAST, ACCEPT_MCAST, PROTO_MASK);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cm_ptr_d    = cm_ptr_q;
        meta_d      = meta_q;
        meta_pend_d = meta_pend_q;
        run_d       = 1'b1;
        cnt_acc_d   = cnt_acc_q;
        cnt_flt_d   = cnt_flt_q;
        cnt_ovf_d   = cnt_ovf_q;
        ram_we      = 1'b0;
        decide      = 1'b0;

        case (state_q)
            S_RECV: begin
                if (s_meta_valid) begin
                    meta_d      = s_meta;
                    meta_pend_d = 1'b1;
                end
                if (beat) begin
                    if (full) begin
                        if (s_tlast) begin
                            wr_ptr_d    = cm_ptr_q;
                            cnt_ovf_d   = cnt_ovf_q + 32'd1;
                            meta_pend_d = 1'b0;
                        end else begin
                            state_d = S_OVF;
                        end
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (s_tlast) begin
                            if (s_meta_valid || meta_pend_q) begin
                                decide = 1'b1;
                            end else begin
                                state_d = S_WAIT_META;
                            end
                        end
                    end
                end
            end
            S_OVF: begin
                if (beat && s_tlast) begin
                    wr_ptr_d    = cm_ptr_q;
                    cnt_ovf_d   = cnt_ovf_q + 32'd1;
                    meta_pend_d = 1'b0;
                    state_d     = S_RECV;
                end
            end
            S_WAIT_META: begin
                if (s_meta_valid) begin
                    decide = 1'b1;
                end
            end
            default: begin
                state_d = S_RECV;
            end
        endcase

        // wr_ptr_d already covers a tlast beat written this cycle
        if (decide) begin
            meta_pend_d = 1'b0;
            state_d     = S_RECV;
            if (accept) begin
                cm_ptr_d  = wr_ptr_d;
                cnt_acc_d = cnt_acc_q + 32'd1;
            end else begin
                wr_ptr_d  = cm_ptr_q;
                cnt_flt_d = cnt_flt_q + 32'd1;
            end
        end
    end

    // Two-stage read pipe: RAM output register, then the m_* register
    assign readable = (rd_ptr_q != cm_ptr_q);
    assign out_load = r1_valid_q && (!m_tvalid_q || m_tready);
    assign rd_en    = readable && (!r1_valid_q || out_load);

    always_comb begin
        rd_ptr_d   = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        r1_valid_d = rd_en || (r1_valid_q && !out_load);
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        if (out_load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = ram_rd[DATA_WIDTH-1:0];
            m_tlast_d  = ram_rd[DATA_WIDTH];
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RECV;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            meta_q      <= '0;
            meta_pend_q <= 1'b0;
            run_q       <= 1'b0;
            cnt_acc_q   <= '0;
            cnt_flt_q   <= '0;
            cnt_ovf_q   <= '0;
            r1_valid_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            meta_q      <= meta_d;
            meta_pend_q <= meta_pend_d;
            run_q       <= run_d;
            cnt_acc_q   <= cnt_acc_d;
            cnt_flt_q   <= cnt_flt_d;
            cnt_ovf_q   <= cnt_ovf_d;
            r1_valid_q  <= r1_valid_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tdata_q   <= m_tdata_d;
        end
    end

    pkt_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data ({s_tlast, s_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (ram_rd)
    );

    assign m_tvalid        = m_tvalid_q;
    assign m_tdata         = m_tdata_q;
    assign m_tlast         = m_tlast_q;
    assign cnt_accept      = cnt_acc_q;
    assign cnt_drop_filter = cnt_flt_q;
    assign cnt_drop_ovf    = cnt_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth_frame_filter
// Brief    : Directed bench for two filter configurations (default, small/strict)
// Revision : 1.0
// ============================================================================
module tb_eth_frame_filter;
    import eth_parser_pkg::*;

    localparam int        NI    = 2;
    localparam mac_addr_t LOCAL = 48'h02_00_00_00_00_01;
    localparam mac_addr_t OTHER = 48'h02_00_00_00_00_99;
    localparam mac_addr_t MCAST = 48'h01_00_5E_00_00_01;

    logic          clk = 1'b0;
    logic          rst_n        [NI];
    logic [7:0]    s_tdata      [NI];
    logic          s_tvalid     [NI];
    logic          s_tready     [NI];
    logic          s_tlast      [NI];
    eth_metadata_t s_meta       [NI];
    logic          s_meta_valid [NI];
    logic [7:0]    m_tdata      [NI];
    logic          m_tvalid     [NI];
    logic          m_tready     [NI];
    logic          m_tlast      [NI];
    logic [31:0]   cnt_acc      [NI];
    logic [31:0]   cnt_flt      [NI];
    logic [31:0]   cnt_ovf      [NI];
    logic          bp_en        [NI];

    int total = 0;
    int bad   = 0;
    int nout [NI];
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    always #5 clk = ~clk;

    eth_frame_filter u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]),
        .s_tready(s_tready[0]), .s_tlast(s_tlast[0]), .s_meta(s_meta[0]),
        .s_meta_valid(s_meta_valid[0]), .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]),
        .m_tready(m_tready[0]), .m_tlast(m_tlast[0]), .cnt_accept(cnt_acc[0]),
        .cnt_drop_filter(cnt_flt[0]), .cnt_drop_ovf(cnt_ovf[0])
    );

    eth_frame_filter #(
        .DEPTH(64), .ACCEPT_BCAST(1'b0), .ACCEPT_MCAST(1'b1), .PROTO_MASK(4'b0101)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]),
        .s_tready(s_tready[1]), .s_tlast(s_tlast[1]), .s_meta(s_meta[1]),
        .s_meta_valid(s_meta_valid[1]), .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]),
        .m_tready(m_tready[1]), .m_tlast(m_tlast[1]), .cnt_accept(cnt_acc[1]),
        .cnt_drop_filter(cnt_flt[1]), .cnt_drop_ovf(cnt_ovf[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void exp_push(input int i, input logic [8:0] v);
        if (i == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    function automatic logic [8:0] exp_pop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Output monitor: scoreboard compare plus hold-under-backpressure check
    logic [8:0] held     [NI];
    logic       hold_pend[NI];
    logic [9:0] mon_exp;
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_n[i] !== 1'b1) begin
                hold_pend[i] = 1'b0;
            end else begin
                if (hold_pend[i]) begin
                    chk($sformatf("hold_valid%0d", i), m_tvalid[i], 1);
                    chk($sformatf("hold_data%0d", i), {m_tlast[i], m_tdata[i]}, held[i]);
                end
                hold_pend[i] = m_tvalid[i] && !m_tready[i];
                held[i]      = {m_tlast[i], m_tdata[i]};
                if (m_tvalid[i] && m_tready[i]) begin
                    mon_exp = (exp_size(i) > 0) ? {1'b1, exp_pop(i)} : 10'h0;
                    chk($sformatf("out%0d_beat%0d", i, nout[i]), {1'b1, m_tlast[i], m_tdata[i]}, mon_exp);
                    nout[i]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (bp_en[i]) m_tready[i] = 1'($urandom_range(0, 1));
            end
        end
    end

    // proto = {unknown, arp, ipv6, ipv4}; mmode 0: meta with tlast, 1: with first beat, 2: mdelay cycles after tlast
    task automatic send_frame(input int i, input mac_addr_t dst, input logic [3:0] proto, input int len,
                              input int mmode, input int mdelay, input logic exp_acc, input logic [7:0] seed,
                              output int low_cycles, output int vld_seen);
        eth_metadata_t md;
        logic [8:0]    beats[$];
        logic [7:0]    d;
        int            t;
        md.dst_mac = dst;
        md.is_unknown = proto[3];
        md.is_arp     = proto[2];
        md.is_ipv6    = proto[1];
        md.is_ipv4    = proto[0];
        low_cycles = 0;
        vld_seen   = 0;
        for (int b = 0; b < len; b++) begin
            d = (b < 6) ? dst[47-8*b -: 8] : seed + 8'(b);
            s_tdata[i]      = d;
            s_tvalid[i]     = 1'b1;
            s_tlast[i]      = (b == len - 1);
            s_meta[i]       = md;
            s_meta_valid[i] = (mmode == 1 && b == 0) || (mmode == 0 && b == len - 1);
            beats.push_back({(b == len - 1), d});
            t = 0;
            @(negedge clk);
            if (m_tvalid[i]) vld_seen++;
            while (s_tready[i] !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) chk("tready_timeout", s_tready[i], 1);
            @(posedge clk);
            #1;
        end
        s_tvalid[i]     = 1'b0;
        s_tlast[i]      = 1'b0;
        s_meta_valid[i] = 1'b0;
        if (mmode == 2) begin
            for (int k = 1; k <= mdelay; k++) begin
                s_meta_valid[i] = (k == mdelay);
                @(negedge clk);
                if (!s_tready[i]) low_cycles++;
                @(posedge clk);
                #1;
            end
            s_meta_valid[i] = 1'b0;
        end
        if (exp_acc) begin
            foreach (beats[k]) exp_push(i, beats[k]);
        end
    endtask

    task automatic drain(input int i);
        int t;
        t = 0;
        while (exp_size(i) > 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk($sformatf("drain%0d", i), exp_size(i), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic mac_addr_t dst_of(input int k);
        case (k)
            0:       return LOCAL;
            1:       return OTHER;
            2:       return BCAST_MAC;
            default: return MCAST;
        endcase
    endfunction

    // Mixed table for the DEPTH=64 / no-bcast / mcast / mask 0101 instance
    int         mx_dst  [20] = '{0, 1, 0, 3, 2, 0, 0, 3, 0, 1, 0, 3, 0, 2, 0, 1, 3, 0, 0, 0};
    logic [3:0] mx_pro  [20] = '{4'h1, 4'h1, 4'h2, 4'h1, 4'h4, 4'h4, 4'h8, 4'h4, 4'h1, 4'h4,
                                 4'h1, 4'h2, 4'h4, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h8, 4'h1};
    int         mx_len  [20] = '{12, 9, 15, 20, 8, 33, 5, 17, 40, 11, 1, 14, 26, 7, 31, 3, 22, 18, 9, 37};
    int         mx_mode [20] = '{0, 0, 1, 0, 0, 2, 0, 1, 0, 2, 0, 0, 1, 0, 2, 0, 0, 1, 0, 0};
    logic       mx_acc  [20] = '{1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1};

    initial begin
        int lc, vs, nsave;
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0; s_tdata[i] = '0; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0;
            s_meta[i] = '0; s_meta_valid[i] = 1'b0; m_tready[i] = 1'b1; bp_en[i] = 1'b0;
            nout[i] = 0; hold_pend[i] = 1'b0; held[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_tready%0d", i), s_tready[i], 0);
            chk($sformatf("rst_tvalid%0d", i), {m_tvalid[i], m_tlast[i], m_tdata[i]}, 0);
            chk($sformatf("rst_cnt%0d", i), {cnt_acc[i], cnt_flt[i]} | 64'(cnt_ovf[i]), 0);
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("tready_after_rst0", s_tready[0], 1);
        chk("tready_after_rst1", s_tready[1], 1);
        @(posedge clk); #1;

        // 64-byte IPv4 unicast, meta with tlast
        send_frame(0, LOCAL, 4'h1, 64, 0, 0, 1'b1, 8'h10, lc, vs);
        chk("store_fwd_no_early_valid", vs, 0);
        @(negedge clk); chk("lat_c0", m_tvalid[0], 0);
        @(negedge clk); chk("lat_c1", m_tvalid[0], 0);
        @(negedge clk); chk("lat_c2", m_tvalid[0], 1);
        drain(0);
        chk("t1_acc", cnt_acc[0], 1);
        chk("t1_nout", nout[0], 64);

        // wrong unicast dropped, next frame intact (early meta)
        send_frame(0, OTHER, 4'h1, 30, 1, 0, 1'b0, 8'h40, lc, vs);
        send_frame(0, LOCAL, 4'h1, 20, 1, 0, 1'b1, 8'h60, lc, vs);
        drain(0);
        chk("t2_flt", cnt_flt[0], 1);
        chk("t2_acc", cnt_acc[0], 2);
        chk("t2_nout", nout[0], 84);

        // broadcast ARP, metadata 5 cycles after tlast
        send_frame(0, BCAST_MAC, 4'h4, 42, 2, 5, 1'b1, 8'h80, lc, vs);
        chk("t3_tready_low_cycles", lc, 5);
        @(negedge clk);
        chk("t3_tready_back", s_tready[0], 1);
        drain(0);
        chk("t3_acc", cnt_acc[0], 3);

        // mcast off, unknown proto masked, IPv6 allowed, single-beat frame
        send_frame(0, MCAST, 4'h1, 10, 0, 0, 1'b0, 8'h20, lc, vs);
        send_frame(0, LOCAL, 4'h8, 10, 0, 0, 1'b0, 8'h30, lc, vs);
        send_frame(0, LOCAL, 4'h2, 12, 0, 0, 1'b1, 8'h50, lc, vs);
        send_frame(0, LOCAL, 4'h1, 1, 0, 0, 1'b1, 8'h70, lc, vs);
        drain(0);
        chk("t4_flt", cnt_flt[0], 3);
        chk("t4_acc", cnt_acc[0], 5);

        // DEPTH=64 overflow with output stalled
        m_tready[1] = 1'b0;
        send_frame(1, LOCAL, 4'h1, 40, 0, 0, 1'b1, 8'h11, lc, vs);
        send_frame(1, LOCAL, 4'h1, 100, 0, 0, 1'b0, 8'h22, lc, vs);
        repeat (4) @(posedge clk); #1;
        chk("t5_ovf", cnt_ovf[1], 1);
        chk("t5_acc", cnt_acc[1], 1);
        chk("t5_no_output", nout[1], 0);
        chk("t5_head_waiting", m_tvalid[1], 1);
        m_tready[1] = 1'b1;
        drain(1);
        chk("t5_nout", nout[1], 40);

        // exact fill, then a tlast beat landing while full rolls back at once
        m_tready[1] = 1'b0;
        send_frame(1, LOCAL, 4'h1, 64, 0, 0, 1'b1, 8'h33, lc, vs);
        send_frame(1, LOCAL, 4'h1, 1, 0, 0, 1'b0, 8'h44, lc, vs);
        repeat (2) @(posedge clk); #1;
        chk("t5b_ovf", cnt_ovf[1], 2);
        chk("t5b_acc", cnt_acc[1], 2);
        m_tready[1] = 1'b1;
        drain(1);
        chk("t5b_nout", nout[1], 104);

        // IPv6 masked, broadcast disabled, multicast accepted
        send_frame(1, LOCAL, 4'h2, 16, 0, 0, 1'b0, 8'h55, lc, vs);
        send_frame(1, BCAST_MAC, 4'h1, 16, 0, 0, 1'b0, 8'h66, lc, vs);
        send_frame(1, MCAST, 4'h1, 22, 0, 0, 1'b1, 8'h77, lc, vs);
        drain(1);
        chk("t6_flt", cnt_flt[1], 2);
        chk("t6_acc", cnt_acc[1], 3);

        // 20 mixed frames under random backpressure
        bp_en[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            int t;
            t = 0;
            while (exp_size(1) > 16 && t < 2000) begin
                @(posedge clk);
                t++;
            end
            #1;
            send_frame(1, dst_of(mx_dst[k]), mx_pro[k], mx_len[k], mx_mode[k], 3,
                       mx_acc[k], 8'(k * 16), lc, vs);
        end
        drain(1);
        bp_en[1] = 1'b0;
        @(posedge clk); #1;
        m_tready[1] = 1'b1;
        chk("t7_acc", cnt_acc[1], 14);
        chk("t7_flt", cnt_flt[1], 11);
        chk("t7_ovf", cnt_ovf[1], 2);

        // reset with a committed frame held and a partial frame in flight
        m_tready[0] = 1'b0;
        send_frame(0, LOCAL, 4'h1, 10, 0, 0, 1'b1, 8'h90, lc, vs);
        for (int b = 0; b < 5; b++) begin
            s_tdata[0] = 8'(8'hA0 + b); s_tvalid[0] = 1'b1; s_tlast[0] = 1'b0;
            @(posedge clk); #1;
        end
        s_tvalid[0] = 1'b0;
        rst_n[0] = 1'b0;
        q0.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t8_rst_tvalid", m_tvalid[0], 0);
        chk("t8_rst_tready", s_tready[0], 0);
        chk("t8_rst_acc", cnt_acc[0], 0);
        chk("t8_rst_flt", cnt_flt[0], 0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        m_tready[0] = 1'b1;
        nsave = nout[0];
        @(posedge clk); #1;
        @(negedge clk);
        chk("t8_tready_after", s_tready[0], 1);
        repeat (5) @(posedge clk); #1;
        chk("t8_no_stale_output", nout[0], nsave);
        send_frame(0, LOCAL, 4'h1, 16, 0, 0, 1'b1, 8'hC0, lc, vs);
        drain(0);
        chk("t8_acc", cnt_acc[0], 1);
        chk("t8_nout", nout[0] - nsave, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/eth_frame_filter.md
ETH_FRAME_FILTER -- requirements
Module: eth_frame_filter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, stream byte-lane width in bits.
REQ-002 Parameter DEPTH, default 2048, packet-buffer entries; SHALL be a power of two and at least 64.
REQ-003 Parameter LOCAL_MAC, default 48'h02_00_00_00_00_01, unicast address accepted.
REQ-004 Parameter ACCEPT_BCAST, default 1, accept dest FF:FF:FF:FF:FF:FF.
REQ-005 Parameter ACCEPT_MCAST, default 0, accept dest with bit 40 set (group bit), broadcast excluded.
REQ-006 Parameter PROTO_MASK, default 4'b0111, enable bits {unknown, arp, ipv6, ipv4} (bit3..bit0).
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-008 Port list: clk  in  1  clock; rst_n  in  1  async active-low reset; s_tdata  in  DATA_WIDTH  parser output data; s_tvalid  in  1; s_tready  out  1; s_tlast  in  1; s_meta  in  eth_metadata_t  parsed metadata; s_meta_valid  in  1  one-cycle metadata strobe; m_tdata  out  DATA_WIDTH; m_tvalid  out  1; m_tready  in  1; m_tlast  out  1; cnt_accept  out  32  frames forwarded; cnt_drop_filter  out  32  frames rejected by filter; cnt_drop_ovf  out  32  frames dropped on buffer overflow.

Function
REQ-009 Store-and-forward: no beat of a frame SHALL appear on m_* before that frame is committed.
REQ-010 Buffer entry = {tlast, tdata}; write pointer wr_ptr, commit pointer cm_ptr, read pointer rd_ptr, each log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-011 Full when wr_ptr - rd_ptr == DEPTH; readable when rd_ptr != cm_ptr.
REQ-012 Write FSM states S_RECV, S_OVF, S_WAIT_META; reset state S_RECV.
REQ-013 S_RECV: s_tready=1; each accepted beat written at wr_ptr, wr_ptr+1.
REQ-014 S_RECV, beat accepted while full: beat discarded, -> S_OVF (or, if s_tlast, roll back immediately: wr_ptr<=cm_ptr, cnt_drop_ovf+1, stay S_RECV).
REQ-015 S_OVF: s_tready=1, beats discarded; on tlast beat wr_ptr<=cm_ptr, cnt_drop_ovf+1, -> S_RECV; metadata for that frame ignored.
REQ-016 s_meta_valid pulse at any cycle of a frame SHALL latch s_meta and set meta_pend; a later pulse in the same frame overwrites.
REQ-017 Tlast beat accepted in S_RECV with meta_pend or s_meta_valid same cycle: decide in that cycle (same-cycle s_meta takes priority); otherwise -> S_WAIT_META.
REQ-018 S_WAIT_META: s_tready=0; on s_meta_valid decide, -> S_RECV. No timeout; missing metadata stalls input indefinitely.
REQ-019 Accept = mac_ok AND proto_ok; mac_ok = (dest==LOCAL_MAC) OR (ACCEPT_BCAST AND dest all-ones) OR (ACCEPT_MCAST AND dest[40] AND not broadcast); proto_ok = OR of PROTO_MASK bits ANDed with is_ipv4/is_ipv6/is_arp/is_unknown.
REQ-020 Accept: cm_ptr<=wr_ptr (including tlast beat), cnt_accept+1. Reject: wr_ptr<=cm_ptr, cnt_drop_filter+1. meta_pend cleared on any decision or overflow rollback.
REQ-021 Read side: registered output stage; m_tvalid asserts 2 cycles after commit into an empty buffer; m_tdata/m_tlast stable while m_tvalid && !m_tready.
REQ-022 Full throughput: back-to-back one beat per cycle when m_tready=1.
REQ-023 Simultaneous commit and read, or rollback and read, SHALL not corrupt pointers; rd_ptr never passes cm_ptr.
REQ-024 Counters wrap at 2^32.

Reset
REQ-025 rst_n low: S_RECV, all pointers 0, meta_pend 0, counters 0, m_tvalid 0, m_tlast 0, m_tdata 0, s_tready 0 during reset, 1 first cycle after.
REQ-026 Reset mid-frame or mid-output discards all buffered and partial frames without counting.

Structure
REQ-027 eth_metadata_t, mac_addr_t and a BCAST_MAC constant SHALL come from eth_parser_pkg; filter state enum added there.
REQ-028 One sub-module: pkt_buffer_ram (simple dual-port, sync read, DEPTH x (DATA_WIDTH+1)).

Verification
REQ-029 64-byte frame to LOCAL_MAC, IPv4, meta with tlast -> 64 beats out, tlast on beat 64, cnt_accept=1.
REQ-030 Frame dest 02:00:00:00:00:99 -> no output, cnt_drop_filter=1; following accepted frame intact.
REQ-031 Broadcast ARP, meta 5 cycles after tlast -> s_tready low 5 cycles, then frame forwarded.
REQ-032 DEPTH=64, m_tready=0, 100-byte frame -> cnt_drop_ovf=1, no output; prior 40-byte committed frame still delivered.
REQ-033 IPv6 frame with PROTO_MASK=4'b0101 -> dropped; random m_tready backpressure on 20 mixed frames -> output matches reference model.
REQ-034 rst_n pulsed mid-frame -> m_tvalid 0, counters 0, next frame forwarded correctly.
